adc_frame_packer: RTL and testbench

Downstream stage of the ADC deserializer block; runs in the same read-clock domain. On each conversion-complete strobe it snapshots the flat `ADC_CHANNELS x ADC_DATA_WIDTH` sample array. It then streams the snapshot as 32-bit AXI-Stream words, one word per channel, with a frame marker on the last word. Frames that arrive while the previous frame is still draining are dropped and counted, never merged.

---
 rtl/adc_pkg.sv | 15 +
 rtl/adc_word_fmt.sv | 28 ++
 rtl/adc_frame_packer.sv | 179 +++++++++++++++++
 tb/tb_adc_frame_packer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared constants for the ADC frame packer slice.
// Output word geometry and FSM state encodings.
package adc_pkg;

  localparam int AXIS_WIDTH       = 32;
  localparam int CH_IDX_WIDTH     = 8;
  localparam int SAMPLE_OUT_WIDTH = 24;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

endpackage

// File: rtl/adc_word_fmt.sv
// Channel mux plus sign extension: index and sample array
// in, one 32-bit stream word out (index in the top byte).
module adc_word_fmt
  import adc_pkg::*;
#(
  parameter int ADC_CHANNELS   = 8,
  parameter int ADC_DATA_WIDTH = 18
) (
  input  logic [CH_IDX_WIDTH-1:0]                ch_idx,
  input  logic [ADC_DATA_WIDTH*ADC_CHANNELS-1:0] samples,
  output logic [AXIS_WIDTH-1:0]                  word
);

  logic signed [ADC_DATA_WIDTH-1:0] smp;

  // Select the indexed channel; an out-of-range index gives zero
  always_comb begin
    smp = '0;
    for (int k = 0; k < ADC_CHANNELS; k++) begin
      if (ch_idx == CH_IDX_WIDTH'(k)) begin
        smp = samples[ADC_DATA_WIDTH*k +: ADC_DATA_WIDTH];
      end
    end
  end

  assign word = {ch_idx, SAMPLE_OUT_WIDTH'(smp)};

endmodule

// File: rtl/adc_frame_packer.sv
// Snapshots the ADC sample array per strobe and streams it as
// AXI-Stream words. Optional header: ADC_PACK_TIMESTAMP_EN.
module adc_frame_packer
  import adc_pkg::*;
#(
  parameter int ADC_CHANNELS   = 8,
  parameter int ADC_DATA_WIDTH = 18,
  parameter int TCQ            = 1
) (
  input  logic                                   adc_read_clk,
  input  logic                                   rstn,
  input  logic [ADC_DATA_WIDTH*ADC_CHANNELS-1:0] adc_data_arr,
  input  logic                                   sample_valid,
  input  logic                                   pack_en,
  output logic [AXIS_WIDTH-1:0]                  m_axis_tdata,
  output logic                                   m_axis_tvalid,
  input  logic                                   m_axis_tready,
  output logic                                   m_axis_tlast,
  output logic                                   overrun,
  input  logic                                   overrun_clr,
  output logic [15:0]                            drop_cnt,
  output logic                                   busy
);

  localparam int ARR_W = ADC_DATA_WIDTH * ADC_CHANNELS;
  localparam logic [CH_IDX_WIDTH-1:0] LAST_IDX =
    CH_IDX_WIDTH'(ADC_CHANNELS - 1);

  if (ADC_CHANNELS < 2 || ADC_CHANNELS > 48 ||
      (ADC_CHANNELS % 2) != 0) begin : g_bad_ch
    $error("ADC_CHANNELS must be even, 2..48");
  end
  if (ADC_DATA_WIDTH < 8 || ADC_DATA_WIDTH > 24) begin : g_bad_w
    $error("ADC_DATA_WIDTH must be 8..24");
  end
  if (TCQ < 0) begin : g_bad_tcq
    $error("TCQ must be non-negative");
  end

  state_t                  state_q, state_d;
  logic [CH_IDX_WIDTH-1:0] ch_idx_q, ch_idx_d;
  logic [ARR_W-1:0]        shadow_q;
  logic [AXIS_WIDTH-1:0]   tdata_d;
  logic                    tvalid_d, tlast_d;
  logic [CH_IDX_WIDTH-1:0] fmt_idx;
  logic [ARR_W-1:0]        fmt_arr;
  logic [AXIS_WIDTH-1:0]   fmt_word;
  logic                    qual, fire, fire_last;
  logic                    accept, drop;

`ifdef ADC_PACK_TIMESTAMP_EN
  logic [AXIS_WIDTH-1:0]   ts_cnt_q;
`endif

  // Qualify strobes; a final-beat handshake frees the slot
  always_comb begin
    qual      = sample_valid && pack_en;
    fire      = m_axis_tvalid && m_axis_tready;
    fire_last = fire && m_axis_tlast;
    accept    = qual && (state_q == ST_IDLE || fire_last);
    drop      = qual && !accept;
  end

  // Feed the formatter the word that will be presented next
  always_comb begin
    fmt_arr = accept ? adc_data_arr : shadow_q;
    if (accept) begin
      fmt_idx = '0;
    end else if (state_q == ST_DATA) begin
      fmt_idx = ch_idx_q + 8'd1;
    end else begin
      fmt_idx = ch_idx_q;
    end
  end

  adc_word_fmt #(
    .ADC_CHANNELS   (ADC_CHANNELS),
    .ADC_DATA_WIDTH (ADC_DATA_WIDTH)
  ) u_fmt (
    .ch_idx  (fmt_idx),
    .samples (fmt_arr),
    .word    (fmt_word)
  );

  // Next-state and next-output for the frame FSM
  always_comb begin
    state_d  = state_q;
    ch_idx_d = ch_idx_q;
    tvalid_d = m_axis_tvalid;
    tdata_d  = m_axis_tdata;
    tlast_d  = m_axis_tlast;
    if (accept) begin
      ch_idx_d = '0;
      tvalid_d = 1'b1;
      tlast_d  = 1'b0;
`ifdef ADC_PACK_TIMESTAMP_EN
      state_d  = ST_HDR;
      tdata_d  = ts_cnt_q;
`else
      state_d  = ST_DATA;
      tdata_d  = fmt_word;
`endif
    end else if (fire) begin
      unique case (state_q)
        ST_HDR: begin
          state_d = ST_DATA;
          tdata_d = fmt_word;
          tlast_d = (ch_idx_q == LAST_IDX);
        end
        ST_DATA: begin
          if (m_axis_tlast) begin
            state_d  = ST_IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end else begin
            ch_idx_d = ch_idx_q + 8'd1;
            tdata_d  = fmt_word;
            tlast_d  = (ch_idx_d == LAST_IDX);
          end
        end
        default: ;
      endcase
    end
  end

  // FSM, beat index and registered stream outputs
  always_ff @(posedge adc_read_clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      ch_idx_q      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_idx_q      <= ch_idx_d;
      m_axis_tvalid <= tvalid_d;
      m_axis_tdata  <= tdata_d;
      m_axis_tlast  <= tlast_d;
      busy          <= (state_d != ST_IDLE);
    end
  end

  // Snapshot of the sample array; contents don't matter after reset
  always_ff @(posedge adc_read_clk) begin
    if (accept) begin
      shadow_q <= adc_data_arr;
    end
  end

  // Sticky overrun flag and saturating drop counter; clear wins
  always_ff @(posedge adc_read_clk or negedge rstn) begin
    if (!rstn) begin
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end else if (overrun_clr) begin
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overrun  <= 1'b1;
      if (drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

`ifdef ADC_PACK_TIMESTAMP_EN
  // Free-running count of every qualified strobe, kept or dropped
  always_ff @(posedge adc_read_clk or negedge rstn) begin
    if (!rstn) begin
      ts_cnt_q <= '0;
    end else if (qual) begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_adc_frame_packer.sv
// Scoreboard bench for adc_frame_packer, default parameters.
// Define ADC_PACK_TIMESTAMP_EN for the header-word build.
module tb_adc_frame_packer;

  localparam int NCH = 8;
  localparam int W   = 18;

  logic           clk = 1'b0;
  logic           rstn;
  logic [W*NCH-1:0] adc_data_arr;
  logic           sample_valid;
  logic           pack_en;
  logic [31:0]    m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tready = 1'b1;
  logic           m_axis_tlast;
  logic           overrun;
  logic           overrun_clr;
  logic [15:0]    drop_cnt;
  logic           busy;

  adc_frame_packer #(
    .ADC_CHANNELS   (NCH),
    .ADC_DATA_WIDTH (W),
    .TCQ            (1)
  ) dut (
    .adc_read_clk  (clk),
    .rstn          (rstn),
    .adc_data_arr  (adc_data_arr),
    .sample_valid  (sample_valid),
    .pack_en       (pack_en),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .overrun       (overrun),
    .overrun_clr   (overrun_clr),
    .drop_cnt      (drop_cnt),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          vals[NCH];
  logic [32:0] sb[$];
  int unsigned ts_model = 0;
  bit          bp_en    = 1'b0;
  bit          stalled  = 1'b0;
  logic [32:0] held;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // tready toggles every cycle while backpressure is enabled
  always @(posedge clk) begin
    #1;
    m_axis_tready = bp_en ? ~m_axis_tready : 1'b1;
  end

  // Output monitor: hold check while stalled, compare on handshake
  always @(negedge clk) begin
    if (!rstn) begin
      stalled = 1'b0;
    end else if (m_axis_tvalid) begin
      if (stalled) begin
        check("hold", {m_axis_tlast, m_axis_tdata}, held);
      end
      if (m_axis_tready) begin
        stalled = 1'b0;
        if (sb.size() == 0) begin
          check("sb_nonempty", sb.size(), 1);
        end else begin
          check("beat", {m_axis_tlast, m_axis_tdata}, sb.pop_front());
        end
      end else begin
        stalled = 1'b1;
        held    = {m_axis_tlast, m_axis_tdata};
      end
    end
  end

  task automatic load_ramp();
    for (int k = 0; k < NCH; k++) vals[k] = k - 4;
  endtask

  task automatic load_rand();
    for (int k = 0; k < NCH; k++)
      vals[k] = int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
  endtask

  task automatic push_frame();
`ifdef ADC_PACK_TIMESTAMP_EN
    sb.push_back({1'b0, 32'(ts_model)});
`endif
    for (int k = 0; k < NCH; k++)
      sb.push_back({(k == NCH - 1), 8'(k), 24'(vals[k])});
  endtask

  // One-cycle strobe from posedge+1; returns at the next posedge+1
  task automatic strobe(input bit accepted);
    for (int k = 0; k < NCH; k++)
      adc_data_arr[W*k +: W] = W'(vals[k]);
    sample_valid = 1'b1;
    if (pack_en) begin
      if (accepted) push_frame();
      ts_model++;
    end
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check(tag, sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_until_last();
    for (int i = 0; i < 100; i++) begin
      if (m_axis_tvalid && m_axis_tlast && m_axis_tready) break;
      @(posedge clk); #1;
    end
    check("reach_last", {m_axis_tvalid, m_axis_tlast}, 2'b11);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn         = 1'b0;
    sample_valid = 1'b0;
    pack_en      = 1'b1;
    overrun_clr  = 1'b0;
    adc_data_arr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // basic frame, ramp k-4, latency one cycle
    load_ramp();
    strobe(1);
    check("lat_tvalid", m_axis_tvalid, 1);
    check("lat_busy", busy, 1);
    wait_drain("basic_drain");
    check("basic_busy_low", busy, 0);

    // backpressure with random samples
    bp_en = 1'b1;
    load_rand();
    strobe(1);
    wait_drain("bp_drain");
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // drop mid-frame, clear priority, plain clear
    load_rand();
    strobe(1);
    repeat (2) @(posedge clk);
    #1;
    load_rand();
    strobe(0);
    check("drop_overrun", overrun, 1);
    check("drop_cnt1", drop_cnt, 1);
    overrun_clr = 1'b1;
    strobe(0);
    overrun_clr = 1'b0;
    check("clr_prio_overrun", overrun, 0);
    check("clr_prio_cnt", drop_cnt, 0);
    strobe(0);
    check("drop2_cnt", drop_cnt, 1);
    wait_drain("drop_drain");
    overrun_clr = 1'b1;
    @(posedge clk); #1;
    overrun_clr = 1'b0;
    check("clr_overrun", overrun, 0);
    check("clr_cnt", drop_cnt, 0);

    // back-to-back: strobe on final-beat acceptance
    load_rand();
    strobe(1);
    wait_until_last();
    load_rand();
    strobe(1);
    check("b2b_tvalid", m_axis_tvalid, 1);
    check("b2b_busy", busy, 1);
    check("b2b_overrun", overrun, 0);
    wait_drain("b2b_drain");

    // pack_en low: idle strobe and mid-frame strobe are ignored
    pack_en = 1'b0;
    strobe(0);
    check("pe_idle_busy", busy, 0);
    check("pe_idle_tvalid", m_axis_tvalid, 0);
    pack_en = 1'b1;
    load_rand();
    strobe(1);
    pack_en = 1'b0;
    @(posedge clk); #1;
    strobe(0);
    check("pe_mid_overrun", overrun, 0);
    wait_drain("pe_drain");
    pack_en = 1'b1;

    // reset during beat 4, then a clean frame
    load_ramp();
    strobe(1);
    for (int i = 0; i < 50; i++) begin
      if (m_axis_tvalid && m_axis_tdata[31:24] == 8'd4) break;
      @(posedge clk); #1;
    end
    check("rst_mid_at4", m_axis_tdata[31:24], 4);
    rstn = 1'b0;
    #1;
    check("arst_tvalid", m_axis_tvalid, 0);
    check("arst_tlast", m_axis_tlast, 0);
    check("arst_busy", busy, 0);
    sb.delete();
    ts_model = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    load_ramp();
    strobe(1);
    wait_drain("post_rst_drain");
    check("end_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
